// File: rtl/booth_controller.sv
// Control FSM for a radix-2 Booth multiplier: sequences operand loads, N add/sub-shift
// iterations, then drives the high and low product words onto the output bus.
module booth_controller #(
  parameter int N  = 6,
  parameter int CW = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] Y0Yminus1,
  output logic       ldX,
  output logic       ldY,
  output logic       ldA,
  output logic       initA,
  output logic       initYminusOne,
  output logic       ldYminusOne,
  output logic       aBarS,
  output logic       shRA,
  output logic       shRY,
  output logic       selL,
  output logic       selR,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LDX   = 3'd1,
    LDY   = 3'd2,
    CHECK = 3'd3,
    SHIFT = 3'd4,
    OUTH  = 3'd5,
    OUTL  = 3'd6
  } state_t;

  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes decode only the registered state; Y0Yminus1 steers just ldA/aBarS in CHECK.
  always_comb begin
    state_d       = IDLE;
    cnt_d         = cnt_q;
    ldX           = 1'b0;
    ldY           = 1'b0;
    ldA           = 1'b0;
    initA         = 1'b0;
    initYminusOne = 1'b0;
    ldYminusOne   = 1'b0;
    aBarS         = 1'b0;
    shRA          = 1'b0;
    shRY          = 1'b0;
    selL          = 1'b0;
    selR          = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    case (state_q)
      IDLE: begin
        busy    = 1'b0;
        state_d = start ? LDX : IDLE;
      end
      LDX: begin
        ldX     = 1'b1;
        state_d = LDY;
      end
      LDY: begin
        ldY           = 1'b1;
        initA         = 1'b1;
        initYminusOne = 1'b1;
        cnt_d         = '0;
        state_d       = CHECK;
      end
      CHECK: begin
        ldA     = Y0Yminus1[1] ^ Y0Yminus1[0];
        aBarS   = Y0Yminus1[1] & ~Y0Yminus1[0];
        state_d = SHIFT;
      end
      SHIFT: begin
        shRA        = 1'b1;
        shRY        = 1'b1;
        ldYminusOne = 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = OUTH;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = CHECK;
        end
      end
      OUTH: begin
        selL    = 1'b1;
        state_d = OUTL;
      end
      OUTL: begin
        selR    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_booth_controller.sv
// Self-checking bench for booth_controller: a behavioural datapath is attached to the
// strobes, and every cycle is compared against a trace derived from Booth recoding of Y.
module tb_booth_controller;

  localparam int N = 6;
  localparam int OPLEN = 2 * N + 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [1:0] Y0Yminus1;
  logic ldX, ldY, ldA, initA, initYminusOne, ldYminusOne, aBarS;
  logic shRA, shRY, selL, selR, busy, done;

  int checks = 0;
  int failures = 0;

  logic [N-1:0] xOp, yOp;
  logic [N-1:0] dX, dY, dA;
  logic dYm1;
  logic [N-1:0] inBus, outBus;
  logic [12:0] obsVec;

  always #5 clk = ~clk;

  booth_controller #(.N(N), .CW(3)) dut (
    .clk(clk), .rst(rst), .start(start), .Y0Yminus1(Y0Yminus1),
    .ldX(ldX), .ldY(ldY), .ldA(ldA), .initA(initA),
    .initYminusOne(initYminusOne), .ldYminusOne(ldYminusOne), .aBarS(aBarS),
    .shRA(shRA), .shRY(shRY), .selL(selL), .selR(selR), .busy(busy), .done(done)
  );

  // Behavioural multiplier datapath driven by the controller strobes.
  assign inBus = ldX ? xOp : (ldY ? yOp : '0);
  assign outBus = selL ? dA : (selR ? dY : '0);
  assign Y0Yminus1 = {dY[0], dYm1};
  assign obsVec = {ldX, ldY, ldA, initA, initYminusOne, ldYminusOne, aBarS,
                   shRA, shRY, selL, selR, busy, done};

  always @(posedge clk) begin
    if (ldX) dX <= inBus;
    if (ldY) dY <= inBus;
    else if (shRY) dY <= {dA[0], dY[N-1:1]};
    if (initA) dA <= '0;
    else if (ldA) dA <= aBarS ? dA - dX : dA + dX;
    else if (shRA) dA <= {dA[N-1], dA[N-1:1]};
    if (initYminusOne) dYm1 <= 1'b0;
    else if (ldYminusOne) dYm1 <= dY[0];
  end

  // Expected strobe vector for cycle c of an operation (c=0 is LDX), from Booth recoding.
  function automatic logic [12:0] expectedVec(input int c, input logic [N-1:0] y);
    logic xLd, yLd, aLd, aInit, ym1Init, ym1Ld, sub, sA, sY, hi, lo, bz, dn;
    logic yi, yprev;
    int k;
    {xLd, yLd, aLd, aInit, ym1Init, ym1Ld, sub, sA, sY, hi, lo, bz, dn} = '0;
    if (c >= 0 && c < OPLEN) begin
      bz = 1'b1;
      if (c == 0) xLd = 1'b1;
      else if (c == 1) begin
        yLd = 1'b1; aInit = 1'b1; ym1Init = 1'b1;
      end else if (c < 2 + 2 * N) begin
        k = (c - 2) / 2;
        if ((c - 2) % 2 == 0) begin
          yi = y[k];
          yprev = (k == 0) ? 1'b0 : y[k-1];
          aLd = yi ^ yprev;
          sub = yi & ~yprev;
        end else begin
          sA = 1'b1; sY = 1'b1; ym1Ld = 1'b1;
        end
      end else if (c == OPLEN - 2) hi = 1'b1;
      else begin
        lo = 1'b1; dn = 1'b1;
      end
    end
    return {xLd, yLd, aLd, aInit, ym1Init, ym1Ld, sub, sA, sY, hi, lo, bz, dn};
  endfunction

  function automatic logic [2*N-1:0] product(input logic [N-1:0] x, input logic [N-1:0] y);
    int px, py;
    px = $signed(x);
    py = $signed(y);
    return (2 * N)'(px * py);
  endfunction

  task automatic applyStimulus(input logic [N-1:0] x, input logic [N-1:0] y);
    xOp = x;
    yOp = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (obsVec !== 13'h0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got %h expected %h", obsVec, 13'h0);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (obsVec !== 13'h0) begin
      failures++;
      $display("[TB] FAIL idle_without_start: got %h expected %h", obsVec, 13'h0);
    end
  endtask

  task automatic test_multiply(input logic [N-1:0] x, input logic [N-1:0] y, input string tag);
    logic [2*N-1:0] p;
    int doneCount = 0;
    int busyCount = 0;
    p = product(x, y);
    applyStimulus(x, y);
    for (int c = 0; c < OPLEN; c++) begin
      @(negedge clk);
      doneCount += int'(done);
      busyCount += int'(busy);
      checks++;
      if (obsVec !== expectedVec(c, y)) begin
        failures++;
        $display("[TB] FAIL %s strobes cycle %0d: got %h expected %h", tag, c, obsVec, expectedVec(c, y));
      end
      if (c == OPLEN - 2) begin
        checks++;
        if (outBus !== p[2*N-1:N]) begin
          failures++;
          $display("[TB] FAIL %s outbus_high: got %b expected %b", tag, outBus, p[2*N-1:N]);
        end
      end
      if (c == OPLEN - 1) begin
        checks++;
        if (outBus !== p[N-1:0]) begin
          failures++;
          $display("[TB] FAIL %s outbus_low: got %b expected %b", tag, outBus, p[N-1:0]);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (obsVec !== 13'h0 || doneCount != 1 || busyCount != OPLEN) begin
      failures++;
      $display("[TB] FAIL %s completion: vec %h done %0d busy %0d expected vec 0 done 1 busy %0d",
               tag, obsVec, doneCount, busyCount, OPLEN);
    end
  endtask

  task automatic test_random_ops(input int count);
    int xi;
    for (int i = 0; i < count; i++) begin
      xi = int'($urandom_range(0, 62)) - 31;
      test_multiply(N'(xi), N'($urandom), "random");
    end
  endtask

  task automatic test_start_during_check();
    logic [N-1:0] y;
    int endCycle = -1;
    y = N'($urandom);
    applyStimulus(N'(9), y);
    for (int c = 0; c < OPLEN + 3; c++) begin
      @(negedge clk);
      checks++;
      if (obsVec !== expectedVec(c, y)) begin
        failures++;
        $display("[TB] FAIL start_in_check cycle %0d: got %h expected %h", c, obsVec, expectedVec(c, y));
      end
      if (done) endCycle = c;
      start = (c == 2 || c == 6);
    end
    start = 1'b0;
    checks++;
    if (endCycle != OPLEN - 1) begin
      failures++;
      $display("[TB] FAIL start_in_check length: done at cycle %0d expected %0d", endCycle, OPLEN - 1);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [N-1:0] y;
    int doneSeen = 0;
    y = 6'b101101;
    applyStimulus(N'(-7), y);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      doneSeen += int'(done);
      checks++;
      if (obsVec !== expectedVec(c, y)) begin
        failures++;
        $display("[TB] FAIL abort_prefix cycle %0d: got %h expected %h", c, obsVec, expectedVec(c, y));
      end
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      doneSeen += int'(done);
      checks++;
      if (obsVec !== 13'h0) begin
        failures++;
        $display("[TB] FAIL abort_idle cycle %0d: got %h expected %h", c, obsVec, 13'h0);
      end
    end
    checks++;
    if (doneSeen != 0) begin
      failures++;
      $display("[TB] FAIL abort_no_done: got %0d pulses expected 0", doneSeen);
    end
    test_multiply(N'(-7), y, "after_abort");
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] y;
    int lastDone = -1;
    int pulses = 0;
    y = 6'b011010;
    applyStimulus(N'(11), y);
    start = 1'b1;
    for (int t = 0; t < 3 * (OPLEN + 1); t++) begin
      @(negedge clk);
      checks++;
      if (obsVec !== expectedVec(t % (OPLEN + 1), y) || (selL && selR)) begin
        failures++;
        $display("[TB] FAIL back_to_back cycle %0d: got %h expected %h", t, obsVec,
                 expectedVec(t % (OPLEN + 1), y));
      end
      if (done) begin
        if (lastDone >= 0) begin
          checks++;
          if (t - lastDone != OPLEN + 1) begin
            failures++;
            $display("[TB] FAIL done_period: got %0d expected %0d", t - lastDone, OPLEN + 1);
          end
        end
        lastDone = t;
        pulses++;
      end
    end
    start = 1'b0;
    checks++;
    if (pulses != 3) begin
      failures++;
      $display("[TB] FAIL back_to_back_pulses: got %0d expected 3", pulses);
    end
    repeat (OPLEN + 2) @(negedge clk);
  endtask

  initial begin
    xOp = '0;
    yOp = '0;
    test_reset();
    test_multiply(N'(5), N'(7), "x5_y7");
    test_multiply(N'(3), N'(-2), "x3_ym2");
    test_multiply(N'(13), N'(0), "y0");
    test_multiply(N'(-31), N'(-32), "extremes");
    test_random_ops(20);
    test_start_during_check();
    test_reset_mid_op();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
